path_reader: RTL and testbench
==============================

# path_reader

Drains the coordinate stack after a maze run and replays the stored path in start-to-end order over a valid/ready stream. It sits on the read side of `stack`: it is the only agent driving `pop` once the solver finishes. It captures popped (x, y) pairs into a local buffer until the stack reports `fail`, then emits them in reverse pop order, oldest entry first.

## Interface
- `W`, default 4: coordinate width, matching stack `xOut`/`yOut`.
- `DEPTH`, default 16: buffer entries; must equal or exceed the stack depth.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `start  in  1`: one-cycle request to begin draining; accepted only in IDLE.
- `pop  out  1`: pop strobe to stack, one cycle wide.
- `stkX  in  W`: stack `xOut`.
- `stkY  in  W`: stack `yOut`.
- `stkFail  in  1`: stack `fail`; high in the cycle after a pop of an empty stack.
- `xPath  out  W`: emitted x coordinate.
- `yPath  out  W`: emitted y coordinate.
- `pathValid  out  1`: output beat valid.
- `pathReady  in  1`: downstream accepts the beat.
- `pathLast  out  1`: marks the final beat, which is the path end.
- `count  out  $clog2(DEPTH+1)`: entries captured.
- `done  out  1`: one-cycle pulse at the end of a run.
- `overflow  out  1`: sticky until the next `start`; buffer filled before the stack emptied.

## Operation
- Stack contract: `pop` sampled at edge N; `stkX`/`stkY`/`stkFail` valid during cycle N+1.
- States: IDLE, POP, CAP, EMIT, FIN.
- IDLE:
  - `start` leads to POP.
  - Clears `count`, `overflow`.
- POP:
  - Asserts `pop` for exactly one cycle.
  - Next state is CAP.
- CAP: samples the stack response.
  - `stkFail` with `count`==0: go to FIN (empty path, no beats).
  - `stkFail` with `count`>0: load `idx`=`count`-1, go to EMIT.
  - Otherwise: write `buf[count]`={stkX,stkY} and increment `count`.
  - If the new `count`==DEPTH: set `overflow`, go to EMIT with `idx`=DEPTH-1 and no further pop.
  - Else go to POP.
- EMIT:
  - Drives `buf[idx]` with `pathValid`=1 and `pathLast`=(`idx`==0).
  - On `pathValid`&&`pathReady`: if `idx`==0 go to FIN, else decrement `idx`.
  - Data and `pathLast` hold stable while `pathReady` is low.
- FIN:
  - `done`=1 for one cycle.
  - Next state is IDLE.
- `start` outside IDLE is ignored.
- Reset mid-run aborts the run:
  - returns to IDLE;
  - `pop` deasserts immediately;
  - buffer contents are don't-care;
  - the stack is left partially drained.

## Timing
- Reset values:
  - state IDLE;
  - `pop`, `pathValid`, `pathLast`, `done`, `overflow` = 0;
  - `count` = 0;
  - `xPath`, `yPath` = 0.
- All outputs are registered or decoded from registered state only. No combinational path from `pathReady` or the stack inputs to any output.
- Drain rate is one entry per 2 cycles (POP, CAP).
- N entries: `start` at edge 0, first `pop` in cycle 1, fail detected at CAP of the (N+1)th pop.
- First `pathValid` appears in cycle 2N+3.
- With `pathReady` held high, one beat per cycle; `done` is asserted one cycle after the last beat.
- `count` and `overflow` hold their values through FIN and IDLE until the next `start`.

## Structure
- Shared package `path_pkg`:
  - state enum `path_state_t`;
  - coordinate typedef `coord_t` (packed {x,y}, 2W bits), shared with `stack` and the solver.
- Sub-module `path_buf`: DEPTH×2W register file, 1 write port, 1 asynchronous read port.
- FSM, `count`/`idx` counters and output registers live in `path_reader`.

## Test plan
- Push (1,0),(2,0),(2,1) into the stack, then `start` with `pathReady`=1:
  - 4 pops;
  - beats (1,0),(2,0),(2,1), with `pathLast` on (2,1);
  - `count`=3;
  - `done` one cycle after the last beat.
- Empty stack, `start`:
  - single `pop`;
  - no `pathValid`;
  - `done` pulses;
  - `count`=0.
- 3 entries, `pathReady` toggling 1-0-0-1-1:
  - beat values hold stable while stalled;
  - exactly 3 handshakes;
  - no duplicate or dropped beat.
- DEPTH=4, stack holding 6 entries:
  - 4 pops only;
  - `overflow`=1;
  - 4 beats, oldest captured first;
  - stack retains 2 entries.
- `rst` low during the second POP: all outputs 0 within the same cycle. A following `start` on a 1-entry stack yields 1 beat with `pathLast`=1.
- `start` asserted repeatedly during EMIT: ignored, `count` unchanged, sequence completes normally.

Source files
------------

// File: rtl/path_pkg.sv
// Shared types for the maze path datapath: FSM states, packed coordinates,
// and an index-width helper used by the path reader and its buffer.
package path_pkg;

  localparam int unsigned COORD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_POP  = 3'd1,
    ST_CAP  = 3'd2,
    ST_EMIT = 3'd3,
    ST_FIN  = 3'd4
  } path_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/path_buf.sv
// Path capture buffer: DEPTH x DW register file, one synchronous write port,
// one asynchronous read port. Contents are not reset.
module path_buf
  import path_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [idx_w(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]           i_wdata,
  input  logic [idx_w(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]           o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/path_reader.sv
// Drains the coordinate stack into a local buffer, then replays the entries
// oldest-first over a valid/ready stream with a last marker.
module path_reader
  import path_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       pop,
  input  logic [W-1:0]               stkX,
  input  logic [W-1:0]               stkY,
  input  logic                       stkFail,
  output logic [W-1:0]               xPath,
  output logic [W-1:0]               yPath,
  output logic                       pathValid,
  input  logic                       pathReady,
  output logic                       pathLast,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output logic                       overflow
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned IW = idx_w(DEPTH);

  path_state_t   r_state;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_idx;
  logic          r_ovf;

  logic          w_we;
  logic [CW-1:0] w_cnt_inc;
  logic [2*W-1:0] w_rdata;

  assign w_we      = (r_state == ST_CAP) && !stkFail;
  assign w_cnt_inc = r_count + 1'b1;

  path_buf #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_buf (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_count[IW-1:0]),
    .i_wdata ({stkX, stkY}),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // count/overflow persist through IDLE so they stay readable after a run
          if (start) begin
            r_state <= ST_POP;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ST_POP:  r_state <= ST_CAP;
        ST_CAP: begin
          if (stkFail) begin
            if (r_count == '0) begin
              r_state <= ST_FIN;
            end else begin
              r_idx   <= IW'(r_count - 1'b1);
              r_state <= ST_EMIT;
            end
          end else begin
            r_count <= w_cnt_inc;
            if (w_cnt_inc == CW'(DEPTH)) begin
              r_ovf   <= 1'b1;
              r_idx   <= IW'(DEPTH - 1);
              r_state <= ST_EMIT;
            end else begin
              r_state <= ST_POP;
            end
          end
        end
        ST_EMIT: begin
          if (pathReady) begin
            if (r_idx == '0) r_state <= ST_FIN;
            else             r_idx   <= r_idx - 1'b1;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Data is gated by EMIT so the unreset buffer never reaches the outputs
  assign pop       = (r_state == ST_POP);
  assign pathValid = (r_state == ST_EMIT);
  assign pathLast  = pathValid && (r_idx == '0);
  assign xPath     = pathValid ? w_rdata[2*W-1:W] : '0;
  assign yPath     = pathValid ? w_rdata[W-1:0]   : '0;
  assign done      = (r_state == ST_FIN);
  assign count     = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_path_reader.sv
// Scoreboard bench for path_reader driven by a behavioural LIFO stack model.
module tb_path_reader;
  import path_pkg::*;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  typedef struct packed {
    coord_t c;
    logic   last;
  } beat_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic          pathReady = 1'b1;
  logic          stkFail   = 1'b0;
  logic [W-1:0]  stkX      = '0;
  logic [W-1:0]  stkY      = '0;
  logic          pop, pathValid, pathLast, done, overflow;
  logic [W-1:0]  xPath, yPath;
  logic [CW-1:0] count;

  logic          push_en = 1'b0;
  logic          clr     = 1'b0;
  coord_t        push_d  = '0;
  coord_t        stk[$];
  int unsigned   pop_cnt = 0;

  beat_t         exp_q[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;

  int            first_v, last_hs, done_cyc;
  int unsigned   n_hs, n_valid, pops;

  always #5 clk = ~clk;

  path_reader #(.W(W), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .pop       (pop),
    .stkX      (stkX),
    .stkY      (stkY),
    .stkFail   (stkFail),
    .xPath     (xPath),
    .yPath     (yPath),
    .pathValid (pathValid),
    .pathReady (pathReady),
    .pathLast  (pathLast),
    .count     (count),
    .done      (done),
    .overflow  (overflow)
  );

  // Stack model: pop sampled at an edge, response valid the following cycle
  always @(posedge clk) begin
    if (clr) stk.delete();
    else if (push_en) stk.push_back(push_d);
    if (pop) begin
      pop_cnt <= pop_cnt + 1;
      if (stk.size() == 0) begin
        stkFail <= 1'b1;
      end else begin
        stkX    <= stk[stk.size()-1].x;
        stkY    <= stk[stk.size()-1].y;
        stkFail <= 1'b0;
        void'(stk.pop_back());
      end
    end else begin
      stkFail <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [3:0] x, input logic [3:0] y, input bit to_sb, input bit last);
    beat_t b;
    push_d  = '{x: x, y: y};
    push_en = 1'b1;
    @(negedge clk);
    push_en = 1'b0;
    if (to_sb) begin
      b.c    = push_d;
      b.last = last;
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_stack();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Starts a run at a negedge in IDLE; cycle k is the k-th cycle after edge 0
  task automatic run(input bit [4:0] pat, input bit start_in_emit);
    beat_t       e;
    logic        stalled;
    logic [8:0]  held;
    int unsigned v;
    int unsigned pops0;
    pops0    = pop_cnt;
    first_v  = -1;
    last_hs  = -1;
    done_cyc = -1;
    n_hs     = 0;
    n_valid  = 0;
    v        = 0;
    stalled  = 1'b0;
    held     = '0;
    start    = 1'b1;
    for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (stalled) check("stall_hold", {23'd0, xPath, yPath, pathLast}, {23'd0, held});
      stalled = 1'b0;
      if (pathValid) begin
        if (first_v < 0) first_v = cyc;
        n_valid++;
        pathReady = pat[v % 5];
        v++;
        if (pathReady) begin
          n_hs++;
          last_hs = cyc;
          if (exp_q.size() == 0) begin
            check("extra_beat", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("beat_xy", {24'd0, xPath, yPath}, {24'd0, e.c});
            check("beat_last", {31'd0, pathLast}, {31'd0, e.last});
          end
        end else begin
          stalled = 1'b1;
          held    = {xPath, yPath, pathLast};
        end
        if (start_in_emit) start = 1'b1;
      end
      if (done) done_cyc = cyc;
    end
    start     = 1'b0;
    pathReady = 1'b1;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    pops = pop_cnt - pops0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset_outs", {22'd0, pop, pathValid, pathLast, done, overflow, count},  32'd0);
    check("reset_xy",   {24'd0, xPath, yPath}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic three-entry path
    load(4'd1, 4'd0, 1'b1, 1'b0);
    load(4'd2, 4'd0, 1'b1, 1'b0);
    load(4'd2, 4'd1, 1'b1, 1'b1);
    run(5'b11111, 1'b0);
    check("basic_pops",    pops,            32'd4);
    check("basic_count",   {29'd0, count},  32'd3);
    check("basic_first_v", first_v,         32'd9);
    check("basic_done",    done_cyc,        last_hs + 1);
    check("basic_hs",      n_hs,            32'd3);
    check("basic_ovf",     {31'd0, overflow}, 32'd0);
    check("basic_sb_empty", exp_q.size(),   32'd0);
    @(negedge clk);

    // Empty stack
    run(5'b11111, 1'b0);
    check("empty_pops",  pops,           32'd1);
    check("empty_valid", n_valid,        32'd0);
    check("empty_done",  done_cyc,       32'd3);
    check("empty_count", {29'd0, count}, 32'd0);
    @(negedge clk);

    // Backpressure 1-0-0-1-1
    load(4'd3, 4'd4, 1'b1, 1'b0);
    load(4'd5, 4'd6, 1'b1, 1'b0);
    load(4'd7, 4'd8, 1'b1, 1'b1);
    run(5'b11001, 1'b0);
    check("stall_hs",    n_hs,    32'd3);
    check("stall_valid", n_valid, 32'd5);
    check("stall_sb_empty", exp_q.size(), 32'd0);
    @(negedge clk);

    // Overflow: six entries, only the newest DEPTH are drained
    load(4'd9, 4'd1, 1'b0, 1'b0);
    load(4'd9, 4'd2, 1'b0, 1'b0);
    load(4'd9, 4'd3, 1'b1, 1'b0);
    load(4'd9, 4'd4, 1'b1, 1'b0);
    load(4'd9, 4'd5, 1'b1, 1'b0);
    load(4'd9, 4'd6, 1'b1, 1'b1);
    run(5'b11111, 1'b0);
    check("ovf_pops",    pops,              32'd4);
    check("ovf_flag",    {31'd0, overflow}, 32'd1);
    check("ovf_count",   {29'd0, count},    32'd4);
    check("ovf_hs",      n_hs,              32'd4);
    check("ovf_first_v", first_v,           32'd9);
    check("ovf_stk_left", stk.size(),       32'd2);
    check("ovf_stk_top", {24'd0, stk[1]},   32'h92);
    @(negedge clk);
    check("ovf_hold_idle", {31'd0, overflow}, 32'd1);
    clear_stack();

    // Reset asserted during the second POP
    load(4'd4, 4'd4, 1'b0, 1'b0);
    load(4'd5, 4'd5, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_pop_seen", {31'd0, pop}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {22'd0, pop, pathValid, pathLast, done, overflow, count}, 32'd0);
    check("mid_rst_xy",   {24'd0, xPath, yPath}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_stk_left", stk.size(), 32'd1);
    exp_q.delete();
    begin
      beat_t b;
      b.c    = '{x: 4'd4, y: 4'd4};
      b.last = 1'b1;
      exp_q.push_back(b);
    end
    run(5'b11111, 1'b0);
    check("post_rst_hs",    n_hs,           32'd1);
    check("post_rst_count", {29'd0, count}, 32'd1);
    @(negedge clk);

    // start held during EMIT is ignored
    load(4'd1, 4'd2, 1'b1, 1'b0);
    load(4'd3, 4'd5, 1'b1, 1'b0);
    load(4'd6, 4'd7, 1'b1, 1'b1);
    run(5'b11111, 1'b1);
    check("restart_hs",    n_hs,           32'd3);
    check("restart_count", {29'd0, count}, 32'd3);
    repeat (3) @(negedge clk);
    check("restart_idle",  {30'd0, pop, pathValid}, 32'd0);
    check("restart_sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
